pid_ctrl_param: RTL

Parametrised, pipelined PID heading controller for the maze-runner drive path. It converts actual/desired heading into signed left/right wheel speed commands around a forward speed. Compared with the single-cycle PID, it adds:
- registered two-stage pipeline with a speed-valid strobe
- configurable D history depth
- conditional-integration anti-windup
- saturated speed outputs
- debounced at-heading flag

---
 rtl/pid_ctrl_param.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/pid_ctrl_param.sv
// Two-stage pipelined PID heading controller: heading error in, saturated left/right wheel speeds out.
// Includes a conditional-integration anti-windup integrator and a debounced at-heading flag.
module pid_ctrl_param #(
  parameter int unsigned HDNG_W      = 12,
  parameter int unsigned ERR_SAT_W   = 10,
  parameter int unsigned INTEG_W     = 16,
  parameter int unsigned I_SHIFT     = 4,
  parameter int          P_COEFF     = 3,
  parameter int          D_COEFF     = 14,
  parameter int unsigned D_DIFF_W    = 8,
  parameter int unsigned D_DEPTH     = 2,
  parameter int unsigned SUM_SHIFT   = 3,
  parameter int unsigned SPD_W       = 12,
  parameter int unsigned AT_HDNG_THR = 30,
  parameter int unsigned AT_HDNG_CNT = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic signed [HDNG_W-1:0] actl_hdng,
  input  logic signed [HDNG_W-1:0] dsrd_hdng,
  input  logic                     hdng_vld,
  input  logic        [SPD_W-2:0]  frwrd_spd,
  input  logic                     moving,
  input  logic                     clr_integ,
  output logic signed [SPD_W-1:0]  lft_spd,
  output logic signed [SPD_W-1:0]  rght_spd,
  output logic                     spd_vld,
  output logic                     at_hdng
);

  // Internal arithmetic width: wide enough that no term or sum can overflow.
  localparam int unsigned MW0   = (ERR_SAT_W > D_DIFF_W) ? ERR_SAT_W : D_DIFF_W;
  localparam int unsigned MW1   = (MW0 > INTEG_W) ? MW0 : INTEG_W;
  localparam int unsigned MW2   = (MW1 > HDNG_W) ? MW1 : HDNG_W;
  localparam int unsigned MW3   = (MW2 > SPD_W) ? MW2 : SPD_W;
  localparam int unsigned SW    = MW3 + 32 + 3;
  localparam int unsigned CNT_W = $clog2(AT_HDNG_CNT + 1);

  localparam logic [CNT_W-1:0]     CNT_MAX = CNT_W'(AT_HDNG_CNT);
  localparam logic signed [SW-1:0] THR     = SW'(AT_HDNG_THR);
  localparam logic signed [SW-1:0] SPD_HI  = (SW'(1) << (SPD_W - 1)) - SW'(1);
  localparam logic signed [SW-1:0] SPD_LO  = ~SPD_HI;

  function automatic logic signed [SW-1:0] sat_to(input logic signed [SW-1:0] x,
                                                   input int unsigned w);
    logic signed [SW-1:0] hi;
    logic signed [SW-1:0] lo;
    hi = (SW'(1) << (w - 1)) - SW'(1);
    lo = ~hi;
    if (x > hi) return hi;
    if (x < lo) return lo;
    return x;
  endfunction

  logic signed [HDNG_W-1:0]    err;
  logic signed [ERR_SAT_W-1:0] err_sat;
  logic signed [ERR_SAT_W-1:0] err_q;
  logic                        vld1;
  logic signed [INTEG_W-1:0]   integ;
  logic signed [ERR_SAT_W-1:0] hist [D_DEPTH];
  logic [CNT_W-1:0]            cnt;
  logic                        lft_hi, lft_lo, rght_hi, rght_lo;

  logic signed [SW-1:0]        p_term, i_term, d_term, pid, fwd;
  logic signed [SW-1:0]        lft_full, rght_full, integ_sum;
  logic signed [SPD_W-1:0]     lft_nxt, rght_nxt;
  logic                        lft_hi_nxt, lft_lo_nxt, rght_hi_nxt, rght_lo_nxt;
  logic                        integ_ok, in_thr;
  logic [CNT_W-1:0]            cnt_nxt;

  // Error, PID terms, output saturation, integrator gating and debounce next-state.
  always_comb begin
    err       = actl_hdng - dsrd_hdng;
    err_sat   = ERR_SAT_W'(sat_to(SW'(err), ERR_SAT_W));

    p_term    = SW'(P_COEFF) * SW'(err_q);
    i_term    = SW'(integ) >>> I_SHIFT;
    d_term    = SW'(D_COEFF) * sat_to(SW'(err_q) - SW'(hist[D_DEPTH-1]), D_DIFF_W);
    pid       = (p_term + i_term + d_term) >>> SUM_SHIFT;

    fwd       = SW'(frwrd_spd);
    lft_full  = fwd + pid;
    rght_full = fwd - pid;

    lft_hi_nxt  = lft_full > SPD_HI;
    lft_lo_nxt  = lft_full < SPD_LO;
    rght_hi_nxt = rght_full > SPD_HI;
    rght_lo_nxt = rght_full < SPD_LO;
    lft_nxt  = lft_hi_nxt  ? SPD_W'(SPD_HI) : lft_lo_nxt  ? SPD_W'(SPD_LO) : SPD_W'(lft_full);
    rght_nxt = rght_hi_nxt ? SPD_W'(SPD_HI) : rght_lo_nxt ? SPD_W'(SPD_LO) : SPD_W'(rght_full);

    // Integrate only if the sum fits and the error does not push a saturated output further.
    integ_sum = SW'(integ) + SW'(err_q);
    integ_ok  = (sat_to(integ_sum, INTEG_W) == integ_sum);
    if ((err_q > 0) && (lft_hi || rght_lo)) integ_ok = 1'b0;
    if ((err_q < 0) && (lft_lo || rght_hi)) integ_ok = 1'b0;

    in_thr  = (SW'(err_q) > -THR) && (SW'(err_q) < THR);
    cnt_nxt = !in_thr ? '0 : (cnt == CNT_MAX) ? cnt : cnt + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q    <= '0;
      vld1     <= 1'b0;
      integ    <= '0;
      for (int k = 0; k < int'(D_DEPTH); k++) hist[k] <= '0;
      cnt      <= '0;
      lft_spd  <= '0;
      rght_spd <= '0;
      spd_vld  <= 1'b0;
      at_hdng  <= 1'b0;
      lft_hi   <= 1'b0;
      lft_lo   <= 1'b0;
      rght_hi  <= 1'b0;
      rght_lo  <= 1'b0;
    end else begin
      vld1 <= hdng_vld;
      if (hdng_vld) err_q <= err_sat;

      if (!moving) begin
        integ    <= '0;
        for (int k = 0; k < int'(D_DEPTH); k++) hist[k] <= '0;
        cnt      <= '0;
        lft_spd  <= '0;
        rght_spd <= '0;
        spd_vld  <= 1'b0;
        at_hdng  <= 1'b0;
        lft_hi   <= 1'b0;
        lft_lo   <= 1'b0;
        rght_hi  <= 1'b0;
        rght_lo  <= 1'b0;
      end else begin
        spd_vld <= vld1;
        if (vld1) begin
          lft_spd  <= lft_nxt;
          rght_spd <= rght_nxt;
          lft_hi   <= lft_hi_nxt;
          lft_lo   <= lft_lo_nxt;
          rght_hi  <= rght_hi_nxt;
          rght_lo  <= rght_lo_nxt;
          hist[0]  <= err_q;
          for (int k = 1; k < int'(D_DEPTH); k++) hist[k] <= hist[k-1];
          cnt      <= cnt_nxt;
          at_hdng  <= (cnt_nxt == CNT_MAX);
        end
        if (clr_integ)             integ <= '0;
        else if (vld1 && integ_ok) integ <= INTEG_W'(integ_sum);
      end
    end
  end

endmodule
